ctrl_combiner_db: RTL and testbench

CTRL_COMBINER_DB -- requirements
Module: ctrl_combiner_db

---
 rtl/ctrl_pkg.sv | 27 ++
 rtl/ctrl_slot.sv | 55 +++++
 rtl/ctrl_combiner_db.sv | 155 +++++++++++++++
 tb/tb_ctrl_combiner_db.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Shared constants and FSM state type for the double-buffered
//            control-word combiner (ctrl_combiner_db, ctrl_slot).
// Options  : none (CTRL_READBACK_EN is consumed by the modules, not here)
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // Default geometry: 64 channels of 16-bit control words.
  localparam int C_CH_COUNT = 64;
  localparam int C_DATA_W   = 16;
  localparam int C_ADDR_W   = 8;

  // Commit handshake states.
  //   ST_IDLE    : shadow and active banks agree
  //   ST_DIRTY   : shadow holds writes not yet committed
  //   ST_PENDING : commit accepted, waiting for the next frame boundary
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIRTY   = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_slot.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_slot
// Purpose  : One channel of the double buffer: a shadow register written by
//            the host and an active register loaded from the shadow on a
//            transfer. A write and a load on the same edge copy the old
//            shadow value into active while the new word lands in shadow.
// Options  : CTRL_READBACK_EN exposes the shadow word as o_shadow.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_slot
  import ctrl_pkg::*;
#(
  parameter int DATA_W = C_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_load,
  output logic [DATA_W-1:0] o_active
`ifdef CTRL_READBACK_EN
  ,
  output logic [DATA_W-1:0] o_shadow
`endif
);

  logic [DATA_W-1:0] r_shadow;
  logic [DATA_W-1:0] r_active;

  // Shadow register: captures host writes for this channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (i_wr_en) begin
      r_shadow <= i_wdata;
    end
  end

  // Active register: takes the pre-edge shadow value on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= '0;
    end else if (i_load) begin
      r_active <= r_shadow;
    end
  end

  assign o_active = r_active;
`ifdef CTRL_READBACK_EN
  assign o_shadow = r_shadow;
`endif

endmodule : ctrl_slot
`default_nettype wire

// File: rtl/ctrl_combiner_db.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_combiner_db
// Purpose  : Double-buffered bank of CH_COUNT control words. Host writes go to
//            a shadow bank; a commit arms a transfer that copies the whole
//            shadow bank to the active bank (combinedout) on the next
//            frame_tick, so outputs only change at waveform-period boundaries.
// Options  : CTRL_READBACK_EN adds rd_addr/rd_data, a registered read port
//            into the shadow bank.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_combiner_db
  import ctrl_pkg::*;
#(
  parameter int CH_COUNT = C_CH_COUNT,
  parameter int DATA_W   = C_DATA_W,
  parameter int ADDR_W   = C_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          signal,
  input  logic [ADDR_W-1:0]          blockaddress,
  input  logic                       write,
  input  logic                       commit,
  input  logic                       frame_tick,
  output logic [CH_COUNT*DATA_W-1:0] combinedout,
  output logic                       commit_ack,
  output logic                       pending,
  output logic                       addr_err
`ifdef CTRL_READBACK_EN
  ,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data
`endif
);

  // One bit wider than the address so CH_COUNT == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] C_CH_LIMIT = (ADDR_W + 1)'(CH_COUNT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_transfer;
  logic              w_addr_ok;
  logic              w_wr_valid;
  logic              r_ack;
  logic              r_err;
  logic [DATA_W-1:0] w_active [CH_COUNT];

  assign w_addr_ok  = ({1'b0, blockaddress} < C_CH_LIMIT);
  assign w_wr_valid = write & w_addr_ok;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and transfer decode. A write coinciding with the transfer is
  // left uncommitted in shadow, so the FSM returns to DIRTY rather than IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_transfer  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_valid) w_state_nxt = ST_DIRTY;
      end
      ST_DIRTY: begin
        if (commit) w_state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        if (frame_tick) begin
          w_transfer  = 1'b1;
          w_state_nxt = w_wr_valid ? ST_DIRTY : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Acknowledge is registered so it lines up with the updated combinedout;
  // addr_err is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= w_transfer;
      r_err <= r_err | (write & ~w_addr_ok);
    end
  end

  assign commit_ack = r_ack;
  assign pending    = (r_state == ST_PENDING);
  assign addr_err   = r_err;

`ifdef CTRL_READBACK_EN
  logic [DATA_W-1:0] w_shadow [CH_COUNT];
  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] r_rd_data;
`endif

  generate
    for (genvar g = 0; g < CH_COUNT; g++) begin : g_slot
      localparam logic [ADDR_W-1:0] C_IDX = ADDR_W'(g);
      ctrl_slot #(
        .DATA_W (DATA_W)
      ) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_en  (w_wr_valid && (blockaddress == C_IDX)),
        .i_wdata  (signal),
        .i_load   (w_transfer),
        .o_active (w_active[g])
`ifdef CTRL_READBACK_EN
        ,
        .o_shadow (w_shadow[g])
`endif
      );
    end
  endgenerate

  // Pack the active bank onto the flat output bus, channel k at k*DATA_W.
  always_comb begin
    combinedout = '0;
    for (int k = 0; k < CH_COUNT; k++) begin
      combinedout[k*DATA_W +: DATA_W] = w_active[k];
    end
  end

`ifdef CTRL_READBACK_EN
  // Readback select; addresses outside the bank match nothing and read 0.
  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < CH_COUNT; k++) begin
      if (rd_addr == ADDR_W'(k)) w_rd_word = w_shadow[k];
    end
  end

  // Readback output register: one-cycle latency from rd_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_word;
    end
  end

  assign rd_data = r_rd_data;
`endif

endmodule : ctrl_combiner_db
`default_nettype wire

// File: tb/tb_ctrl_combiner_db.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_combiner_db
// Purpose  : Self-checking bench for ctrl_combiner_db: a directed vector
//            table, hand-written corner sequences and a randomized run
//            against a bank-level reference model.
// Options  : CTRL_READBACK_EN enables the readback port checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_combiner_db;

  localparam int CH   = 64;
  localparam int CH48 = 48;
  localparam int DW   = 16;
  localparam int AW   = 8;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic [DW-1:0]  sig   = '0;
  logic [AW-1:0]  addr  = '0;
  logic           wr    = 1'b0;
  logic           cm    = 1'b0;
  logic           ft    = 1'b0;

  logic [CH*DW-1:0]   co;
  logic               ack, pend, err;
  logic [CH48*DW-1:0] co48;
  logic               ack48, pend48, err48;
`ifdef CTRL_READBACK_EN
  logic [AW-1:0]  rd_addr = '0;
  logic [DW-1:0]  rd_data, rd_data48;
`endif

  always #5 clk = ~clk;

  ctrl_combiner_db #(.CH_COUNT(CH), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .signal(sig), .blockaddress(addr), .write(wr),
    .commit(cm), .frame_tick(ft), .combinedout(co), .commit_ack(ack),
    .pending(pend), .addr_err(err)
`ifdef CTRL_READBACK_EN
    , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
  );

  ctrl_combiner_db #(.CH_COUNT(CH48), .DATA_W(DW), .ADDR_W(AW)) dut48 (
    .clk(clk), .rst_n(rst_n), .signal(sig), .blockaddress(addr), .write(wr),
    .commit(cm), .frame_tick(ft), .combinedout(co48), .commit_ack(ack48),
    .pending(pend48), .addr_err(err48)
`ifdef CTRL_READBACK_EN
    , .rd_addr(rd_addr), .rd_data(rd_data48)
`endif
  );

  // ---------------- reference model (64-channel instance) -----------------
  // Two flags describe the handshake: m_dirty = uncommitted writes exist,
  // m_pend = a commit is armed and waiting for the frame boundary.
  logic [DW-1:0] m_sh  [CH];
  logic [DW-1:0] m_act [CH];
  bit m_pend, m_dirty, m_ack, m_err;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void model_reset();
    for (int k = 0; k < CH; k++) begin
      m_sh[k]  = '0;
      m_act[k] = '0;
    end
    m_pend = 0; m_dirty = 0; m_ack = 0; m_err = 0;
  endfunction

  function automatic void model_edge();
    bit valid;
    valid = wr && (int'(addr) < CH);
    m_ack = 0;
    if (wr && !valid) m_err = 1;
    if (m_pend && ft) begin
      m_act   = m_sh;            // copy happens before this edge's write lands
      m_ack   = 1;
      m_pend  = 0;
      m_dirty = valid;
    end else if (!m_pend) begin
      if (m_dirty && cm) begin
        m_pend  = 1;
        m_dirty = 0;
      end else if (valid) begin
        m_dirty = 1;
      end
    end
    if (valid) m_sh[addr] = sig;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void check_model();
    int bad_k;
    chk("pending", 32'(pend), 32'(m_pend));
    chk("commit_ack", 32'(ack), 32'(m_ack));
    chk("addr_err", 32'(err), 32'(m_err));
    bad_k = -1;
    for (int k = CH - 1; k >= 0; k--) begin
      if (co[k*DW +: DW] !== m_act[k]) bad_k = k;
    end
    n_cmp++;
    if (bad_k >= 0) begin
      n_bad++;
      $display("FAIL combinedout ch%0d: got 0x%0h, expected 0x%0h (t=%0t)",
               bad_k, co[bad_k*DW +: DW], m_act[bad_k], $time);
    end
  endfunction

  // One clock cycle: drive inputs, step model at the edge, check #1 later.
  task automatic cyc(input bit w, input int a, input logic [DW-1:0] d, input bit c, input bit f);
    wr = w; addr = a[AW-1:0]; sig = d; cm = c; ft = f;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
    wr = 0; cm = 0; ft = 0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_combinedout", 32'(|co), 32'd0);
    chk("rst_pending", 32'(pend), 32'd0);
    chk("rst_commit_ack", 32'(ack), 32'd0);
    chk("rst_addr_err", 32'(err | err48), 32'd0);
    chk("rst_combinedout48", 32'(|co48), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit            w;
    int            a;
    logic [DW-1:0] d;
    bit            c;
    bit            f;
    bit            e_ack;
    bit            e_pend;
    logic [DW-1:0] e_ch3;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, pends;

    //            w  a  d        c  f  ack pend ch3
    tbl[0]  = '{0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000};  // idle
    tbl[1]  = '{0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000};  // commit in IDLE ignored
    tbl[2]  = '{1, 3, 16'h1111, 0, 0, 0, 0, 16'h0000};  // -> DIRTY
    tbl[3]  = '{0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000};  // tick without commit
    tbl[4]  = '{0, 0, 16'h0000, 1, 1, 0, 1, 16'h0000};  // commit+tick: PENDING only
    tbl[5]  = '{0, 0, 16'h0000, 1, 0, 0, 1, 16'h0000};  // repeated commit no-op
    tbl[6]  = '{1, 4, 16'h2222, 0, 0, 0, 1, 16'h0000};  // write while PENDING
    tbl[7]  = '{0, 0, 16'h0000, 0, 1, 1, 0, 16'h1111};  // transfer
    tbl[8]  = '{0, 0, 16'h0000, 0, 0, 0, 0, 16'h1111};
    tbl[9]  = '{0, 0, 16'h0000, 1, 0, 0, 0, 16'h1111};  // commit in IDLE ignored
    tbl[10] = '{1, 3, 16'h3333, 0, 1, 0, 0, 16'h1111};
    tbl[11] = '{0, 0, 16'h0000, 0, 1, 0, 0, 16'h1111};
    tbl[12] = '{0, 0, 16'h0000, 1, 0, 0, 1, 16'h1111};
    tbl[13] = '{1, 3, 16'h4444, 0, 1, 1, 0, 16'h3333};  // write on transfer edge
    tbl[14] = '{0, 0, 16'h0000, 1, 0, 0, 1, 16'h3333};  // commit taken: was DIRTY
    tbl[15] = '{0, 0, 16'h0000, 0, 1, 1, 0, 16'h4444};

    // ---------------- directed table ----------------
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].c, tbl[i].f);
      chk($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_pending", i), 32'(pend), 32'(tbl[i].e_pend));
      chk($sformatf("tbl%0d_ch3", i), 32'(co[3*DW +: DW]), 32'(tbl[i].e_ch3));
    end
    chk("tbl_ch4", 32'(co[4*DW +: DW]), 32'h2222);

    // ---------------- writes without commit ----------------
    do_reset();
    cyc(1, 0, 16'h0004, 0, 0);
    cyc(1, 63, 16'h00FC, 0, 0);
    acks = 0;
    repeat (10) begin
      cyc(0, 0, 16'h0, 0, 1);
      acks += int'(ack);
    end
    chk("nocommit_combinedout", 32'(|co), 32'd0);
    chk("nocommit_acks", 32'(acks), 32'd0);

    // ---------------- full bank commit ----------------
    do_reset();
    for (int i = 0; i < CH; i++) cyc(1, i, 16'(i << 2), 0, 0);
    acks = 0; pends = 0;
    cyc(0, 0, 16'h0, 1, 0); pends += int'(pend); acks += int'(ack);
    cyc(0, 0, 16'h0, 0, 0); pends += int'(pend); acks += int'(ack);
    cyc(0, 0, 16'h0, 0, 0); pends += int'(pend); acks += int'(ack);
    cyc(0, 0, 16'h0, 0, 1); pends += int'(pend); acks += int'(ack);
    cyc(0, 0, 16'h0, 0, 0); pends += int'(pend); acks += int'(ack);
    chk("bank_pending_cycles", 32'(pends), 32'd3);
    chk("bank_acks", 32'(acks), 32'd1);
    chk("bank_ch63", 32'(co[1023:1008]), 32'h00FC);
    chk("bank_ch0", 32'(co[15:0]), 32'h0000);

    // ---------------- write on the transfer edge ----------------
    cyc(1, 6, 16'h0AAA, 0, 0);
    cyc(0, 0, 16'h0, 1, 0);
    chk("edge_pending", 32'(pend), 32'd1);
    cyc(1, 5, 16'hBEEF, 0, 1);
    chk("edge_ack", 32'(ack), 32'd1);
    chk("edge_ch5_old", 32'(co[5*DW +: DW]), 32'h0014);
    chk("edge_ch6", 32'(co[6*DW +: DW]), 32'h0AAA);
    cyc(0, 0, 16'h0, 1, 0);
    chk("edge_dirty_commit", 32'(pend), 32'd1);
    cyc(0, 0, 16'h0, 0, 1);
    chk("edge_ch5_new", 32'(co[5*DW +: DW]), 32'hBEEF);

    // ---------------- out-of-range address (48-channel instance) ----------------
    do_reset();
    cyc(1, 50, 16'h1234, 0, 0);
    chk("oor_err48", 32'(err48), 32'd1);
    chk("oor_err64", 32'(err), 32'd0);
    cyc(0, 0, 16'h0, 1, 0);
    chk("oor_pending48", 32'(pend48), 32'd0);
    cyc(0, 0, 16'h0, 0, 1);
    cyc(0, 0, 16'h0, 1, 1);
    chk("oor_co48", 32'(|co48), 32'd0);
    chk("oor_ack48", 32'(ack48), 32'd0);
    chk("oor_err48_sticky", 32'(err48), 32'd1);
    do_reset();
    chk("oor_err48_cleared", 32'(err48), 32'd0);

    // ---------------- reset while PENDING ----------------
    cyc(1, 2, 16'h5555, 0, 0);
    cyc(0, 0, 16'h0, 1, 0);
    cyc(0, 0, 16'h0, 0, 1);
    chk("rstp_ch2_before", 32'(co[2*DW +: DW]), 32'h5555);
    cyc(1, 2, 16'h6666, 0, 0);
    cyc(0, 0, 16'h0, 1, 0);
    chk("rstp_pending", 32'(pend), 32'd1);
    do_reset();
    acks = 0;
    repeat (5) begin
      cyc(0, 0, 16'h0, 0, 1);
      acks += int'(ack);
    end
    chk("rstp_acks", 32'(acks), 32'd0);
    chk("rstp_combinedout", 32'(|co), 32'd0);

    // ---------------- randomized run against the model ----------------
    for (int n = 0; n < 600; n++) begin
      if (n % 200 == 199) do_reset();
      cyc(bit'($urandom_range(0, 1)), int'($urandom_range(0, 69)), 16'($urandom),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end

`ifdef CTRL_READBACK_EN
    // ---------------- readback port ----------------
    do_reset();
    cyc(1, 7, 16'h0A5A, 0, 0);
    rd_addr = 8'd7;
    cyc(0, 0, 16'h0, 0, 0);
    chk("rd_ch7", 32'(rd_data), 32'h0A5A);
    chk("rd48_ch7", 32'(rd_data48), 32'h0A5A);
    rd_addr = 8'd50;
    cyc(0, 0, 16'h0, 0, 0);
    chk("rd48_out_of_range", 32'(rd_data48), 32'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ctrl_combiner_db
`default_nettype wire
